// File: rtl/led_matrix_scan_if.sv
// Frame/enable inputs and column/row drive outputs of the LED matrix scanner.
// LED_DIM_EN adds the 3-bit dim control.
interface led_matrix_scan_if;
  logic            enable;
  logic [7:0][23:0] board;
  logic            ds;
  logic            sh_cp;
  logic            st_cp;
  logic            oe_n;
  logic [7:0]      row_sel;
  logic            frame_done;
`ifdef LED_DIM_EN
  logic [2:0]      dim;

  modport master (output enable, board, dim,
                  input  ds, sh_cp, st_cp, oe_n, row_sel, frame_done);
  modport slave  (input  enable, board, dim,
                  output ds, sh_cp, st_cp, oe_n, row_sel, frame_done);
`else
  modport master (output enable, board,
                  input  ds, sh_cp, st_cp, oe_n, row_sel, frame_done);
  modport slave  (input  enable, board,
                  output ds, sh_cp, st_cp, oe_n, row_sel, frame_done);
`endif
endinterface

// File: rtl/led_matrix_scan.sv
// 8x8 RGB matrix scan driver: snapshots a frame, shifts each row MSB-first into the
// column shift registers, latches it and lights the row. LED_DIM_EN adds PWM dimming.
module led_matrix_scan #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned ROW_HOLD = 2000
) (
  input logic              clk,
  input logic              reset,
  led_matrix_scan_if.slave bus
);
  localparam int unsigned CntMax = (2 * CLK_DIV > ROW_HOLD) ? 2 * CLK_DIV : ROW_HOLD;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] ShiftLast = CntW'(2 * CLK_DIV - 1);
  localparam logic [CntW-1:0] HalfCnt   = CntW'(CLK_DIV);
  localparam logic [CntW-1:0] LatchLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(ROW_HOLD - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StLatch, StHold} state_e;

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [4:0]       r_bit, w_bit_d;
  logic [2:0]       r_row, w_row_d;
  logic [7:0][23:0] r_snap, w_snap_d;
  logic             w_frame_end;

  logic       r_ds, r_sh_cp, r_st_cp, r_oe_n, r_frame_done;
  logic [7:0] r_row_sel;
  logic       w_ds_d, w_sh_cp_d, w_st_cp_d, w_oe_n_d;
  logic [7:0] w_row_sel_d;

`ifdef LED_DIM_EN
  logic [2:0]  r_dim;
  logic [31:0] w_on_cnt;

  assign w_on_cnt = ((32'(r_dim) + 32'd1) * ROW_HOLD) >> 3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dim <= 3'd7;
    end else if (r_state == StLoad) begin
      r_dim <= bus.dim;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= 5'd23;
      r_row   <= 3'd0;
      r_snap  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_row   <= w_row_d;
      r_snap  <= w_snap_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_bit_d     = r_bit;
    w_row_d     = r_row;
    w_snap_d    = r_snap;
    w_frame_end = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.enable) w_state_d = StLoad;
      end
      StLoad: begin
        w_snap_d  = bus.board;
        w_row_d   = 3'd0;
        w_bit_d   = 5'd23;
        w_cnt_d   = '0;
        w_state_d = StShift;
      end
      StShift: begin
        if (r_cnt == ShiftLast) begin
          w_cnt_d = '0;
          if (r_bit == 5'd0) w_state_d = StLatch;
          else               w_bit_d   = r_bit - 5'd1;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StLatch: begin
        if (r_cnt == LatchLast) begin
          w_cnt_d   = '0;
          w_state_d = StHold;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StHold: begin
        if (r_cnt == HoldLast) begin
          w_cnt_d = '0;
          if (r_row == 3'd7) begin
            w_frame_end = 1'b1;
            w_state_d   = bus.enable ? StLoad : StIdle;
          end else begin
            w_row_d   = r_row + 3'd1;
            w_bit_d   = 5'd23;
            w_state_d = StShift;
          end
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs decode the next state so the registered pins line up with the state they describe.
  always_comb begin
    w_ds_d      = 1'b0;
    w_sh_cp_d   = 1'b0;
    w_st_cp_d   = 1'b0;
    w_oe_n_d    = 1'b1;
    w_row_sel_d = '0;
    unique case (w_state_d)
      StShift: begin
        w_ds_d    = w_snap_d[w_row_d][w_bit_d];
        w_sh_cp_d = (w_cnt_d >= HalfCnt);
      end
      StLatch: w_st_cp_d = 1'b1;
      StHold: begin
        w_row_sel_d = 8'd1 << w_row_d;
`ifdef LED_DIM_EN
        w_oe_n_d    = !(32'(w_cnt_d) < w_on_cnt);
`else
        w_oe_n_d    = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ds         <= 1'b0;
      r_sh_cp      <= 1'b0;
      r_st_cp      <= 1'b0;
      r_oe_n       <= 1'b1;
      r_row_sel    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_ds         <= w_ds_d;
      r_sh_cp      <= w_sh_cp_d;
      r_st_cp      <= w_st_cp_d;
      r_oe_n       <= w_oe_n_d;
      r_row_sel    <= w_row_sel_d;
      r_frame_done <= w_frame_end;
    end
  end

  assign bus.ds         = r_ds;
  assign bus.sh_cp      = r_sh_cp;
  assign bus.st_cp      = r_st_cp;
  assign bus.oe_n       = r_oe_n;
  assign bus.row_sel    = r_row_sel;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: observes the shift/latch/row pins frame by frame
// and compares against expectations derived from the board written and the timing formulas.
`timescale 1ns/1ps
module tb_led_matrix_scan;
  localparam int unsigned CD = 1;
`ifdef LED_DIM_EN
  localparam int unsigned RH = 8;
`else
  localparam int unsigned RH = 4;
`endif
  localparam int FrameLen = 1 + 8 * (48 * CD + CD + RH);
  localparam int Budget   = 5 * FrameLen;
  localparam logic [12:0] IdleOut = 13'h0200; // {ds,sh_cp,st_cp,oe_n,row_sel,frame_done}

  logic clk   = 1'b0;
  logic reset = 1'b0;

  led_matrix_scan_if bus ();

  led_matrix_scan #(.CLK_DIV(CD), .ROW_HOLD(RH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [23:0] obs_word   [8];
  int          obs_edges  [8];
  int          obs_shhi   [8];
  int          obs_st     [8];
  int          obs_hold   [8];
  int          obs_oelo   [8];
  logic [7:0]  obs_rowsel [8];
  bit          obs_oe_order_bad;
  bit          obs_timeout;
  int          obs_len;

  function automatic logic [7:0][23:0] rand_board();
    logic [7:0][23:0] b;
    for (int r = 0; r < 8; r++) b[r] = 24'($urandom);
    return b;
  endfunction

`ifdef LED_DIM_EN
  function automatic int exp_on(input int d);
    return ((d + 1) * RH) >> 3;
  endfunction
`endif

  // Records one frame's pin activity per row; optionally pokes board/enable at a row start.
  task automatic observe_frame(input int chg_seg, input logic [7:0][23:0] chg_board,
                               input int drop_seg, input int raise_seg);
    int seg, edges, shhi, st;
    bit prev_sh, prev_hold, oe_off;
    logic [23:0] word;
    seg = 0; edges = 0; shhi = 0; st = 0;
    prev_sh = 1'b0; prev_hold = 1'b0; oe_off = 1'b0; word = '0;
    obs_len = 0; obs_timeout = 1'b0; obs_oe_order_bad = 1'b0;
    for (int r = 0; r < 8; r++) begin
      obs_word[r] = '0; obs_edges[r] = 0; obs_shhi[r] = 0; obs_st[r] = 0;
      obs_hold[r] = 0; obs_oelo[r] = 0; obs_rowsel[r] = '0;
    end
    forever begin
      @(negedge clk);
      obs_len++;
      if (bus.frame_done === 1'b1) break;
      if (obs_len > Budget) begin
        obs_timeout = 1'b1;
        break;
      end
      if (bus.row_sel != 8'h00) begin
        if (!prev_hold) begin
          obs_word[seg] = word; obs_edges[seg] = edges; obs_shhi[seg] = shhi;
          obs_st[seg] = st; obs_rowsel[seg] = bus.row_sel; oe_off = 1'b0;
        end
        obs_hold[seg]++;
        if (bus.oe_n == 1'b0) begin
          obs_oelo[seg]++;
          if (oe_off) obs_oe_order_bad = 1'b1;
        end else begin
          oe_off = 1'b1;
        end
      end else begin
        if (prev_hold) begin
          if (seg < 7) seg++;
          word = '0; edges = 0; shhi = 0; st = 0;
          if (seg == chg_seg)   bus.board  = chg_board;
          if (seg == drop_seg)  bus.enable = 1'b0;
          if (seg == raise_seg) bus.enable = 1'b1;
        end
        if (bus.sh_cp && !prev_sh) begin
          word = {word[22:0], bus.ds};
          edges++;
        end
        if (bus.sh_cp) shhi++;
        if (bus.st_cp) st++;
      end
      prev_sh   = bus.sh_cp;
      prev_hold = (bus.row_sel != 8'h00);
    end
  endtask

  task automatic test_reset();
    logic [12:0] got;
    bit bad;
    #2 reset = 1'b1;
    #1 got = {bus.ds, bus.sh_cp, bus.st_cp, bus.oe_n, bus.row_sel, bus.frame_done};
    checks++;
    if (got !== IdleOut) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", got, IdleOut);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got = {bus.ds, bus.sh_cp, bus.st_cp, bus.oe_n, bus.row_sel, bus.frame_done};
      if (got !== IdleOut) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle_no_enable last=%h exp=%h", got, IdleOut);
    end
  endtask

  task automatic test_row0();
    logic [7:0][23:0] b;
    b = rand_board();
    b[0] = 24'hA500FF;
    bus.board  = b;
    bus.enable = 1'b1;
    observe_frame(-1, '0, -1, -1);
    checks++;
    if (obs_timeout || obs_len != FrameLen + 1) begin
      failures++;
      $display("FAIL first_frame_len got=%0d exp=%0d timeout=%0b", obs_len, FrameLen + 1,
               obs_timeout);
    end
    checks++;
    if (obs_word[0] !== 24'hA500FF || obs_edges[0] != 24) begin
      failures++;
      $display("FAIL row0_data got=%h edges=%0d exp=a500ff edges=24", obs_word[0], obs_edges[0]);
    end
    checks++;
    if (obs_st[0] != CD || obs_rowsel[0] !== 8'h01 || obs_hold[0] != RH || obs_oelo[0] != RH)
    begin
      failures++;
      $display("FAIL row0_latch_hold st=%0d rowsel=%h hold=%0d oelo=%0d exp st=%0d 01 %0d %0d",
               obs_st[0], obs_rowsel[0], obs_hold[0], obs_oelo[0], CD, RH, RH);
    end
    for (int r = 1; r < 8; r++) begin
      checks++;
      if (obs_word[r] !== b[r]) begin
        failures++;
        $display("FAIL row0_frame_word row=%0d got=%h exp=%h", r, obs_word[r], b[r]);
      end
    end
  endtask

  task automatic test_frame_period();
    logic [7:0][23:0] b;
    for (int f = 0; f < 2; f++) begin
      b = rand_board();
      bus.board = b;
      // Second frame: drop and re-raise enable mid-frame, which must be seamless.
      observe_frame(-1, '0, (f == 1) ? 2 : -1, (f == 1) ? 5 : -1);
      checks++;
      if (obs_timeout || obs_len != FrameLen) begin
        failures++;
        $display("FAIL frame_period f=%0d got=%0d exp=%0d", f, obs_len, FrameLen);
      end
      for (int r = 0; r < 8; r++) begin
        checks++;
        if (obs_word[r] !== b[r] || obs_edges[r] != 24 || obs_shhi[r] != 24 * CD ||
            obs_rowsel[r] !== 8'(1 << r)) begin
          failures++;
          $display("FAIL frame_row f=%0d row=%0d word=%h/%h edges=%0d/24 shhi=%0d/%0d sel=%h/%h",
                   f, r, obs_word[r], b[r], obs_edges[r], obs_shhi[r], 24 * CD,
                   obs_rowsel[r], 8'(1 << r));
        end
      end
    end
  endtask

  task automatic test_midframe_change();
    logic [7:0][23:0] ones;
    ones = '1;
    bus.board = '0;
    observe_frame(3, ones, -1, -1);
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (obs_word[r] !== 24'h000000) begin
        failures++;
        $display("FAIL snapshot_hold row=%0d got=%h exp=000000", r, obs_word[r]);
      end
    end
    observe_frame(-1, '0, -1, -1);
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (obs_word[r] !== 24'hFFFFFF) begin
        failures++;
        $display("FAIL snapshot_next row=%0d got=%h exp=ffffff", r, obs_word[r]);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0][23:0] b;
    bit bad;
    b = rand_board();
    bus.board = b;
    observe_frame(-1, '0, 2, -1);
    checks++;
    if (obs_timeout || obs_len != FrameLen) begin
      failures++;
      $display("FAIL drop_frame_len got=%0d exp=%0d", obs_len, FrameLen);
    end
    for (int r = 2; r < 8; r++) begin
      checks++;
      if (obs_word[r] !== b[r] || obs_rowsel[r] !== 8'(1 << r)) begin
        failures++;
        $display("FAIL drop_row row=%0d word=%h/%h sel=%h", r, obs_word[r], b[r], obs_rowsel[r]);
      end
    end
    bad = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (bus.oe_n !== 1'b1 || bus.row_sel !== 8'h00 || bus.sh_cp !== 1'b0 ||
          bus.st_cp !== 1'b0 || bus.frame_done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL drop_idle oe_n=%b row_sel=%h sh_cp=%b exp 1 00 0", bus.oe_n, bus.row_sel,
               bus.sh_cp);
    end
  endtask

  task automatic test_reset_midshift();
    logic [7:0][23:0] b;
    logic [12:0] got;
    int n;
    bit found;
    b = rand_board();
    bus.board  = b;
    bus.enable = 1'b1;
    n = 0;
    found = 1'b0;
    while (n < Budget && !found) begin
      @(negedge clk);
      n++;
      if (bus.sh_cp === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_sh_cp got=timeout exp=sh_cp high");
    end
    #2 reset = 1'b1;
    #1 got = {bus.ds, bus.sh_cp, bus.st_cp, bus.oe_n, bus.row_sel, bus.frame_done};
    checks++;
    if (got !== IdleOut) begin
      failures++;
      $display("FAIL reset_midshift got=%h exp=%h", got, IdleOut);
    end
    @(negedge clk);
    reset = 1'b0;
    observe_frame(-1, '0, -1, -1);
    checks++;
    if (obs_timeout || obs_len != FrameLen + 1 || obs_rowsel[0] !== 8'h01) begin
      failures++;
      $display("FAIL restart_len got=%0d sel0=%h exp=%0d 01", obs_len, obs_rowsel[0],
               FrameLen + 1);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (obs_word[r] !== b[r]) begin
        failures++;
        $display("FAIL restart_word row=%0d got=%h exp=%h", r, obs_word[r], b[r]);
      end
    end
  endtask

`ifdef LED_DIM_EN
  task automatic test_dim();
    int dims [3];
    dims[0] = 3;
    dims[1] = 7;
    dims[2] = int'($urandom_range(0, 7));
    for (int k = 0; k < 3; k++) begin
      bus.dim   = 3'(dims[k]);
      bus.board = rand_board();
      observe_frame(-1, '0, -1, -1);
      for (int r = 0; r < 8; r++) begin
        checks++;
        if (obs_hold[r] != RH || obs_oelo[r] != exp_on(dims[k]) || obs_oe_order_bad ||
            obs_rowsel[r] !== 8'(1 << r)) begin
          failures++;
          $display("FAIL dim d=%0d row=%0d hold=%0d/%0d oelo=%0d/%0d order_bad=%0b sel=%h",
                   dims[k], r, obs_hold[r], RH, obs_oelo[r], exp_on(dims[k]),
                   obs_oe_order_bad, obs_rowsel[r]);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.enable = 1'b0;
    bus.board  = '0;
`ifdef LED_DIM_EN
    bus.dim    = 3'd7;
`endif
    test_reset();
    test_row0();
    test_frame_period();
    test_midframe_change();
    test_enable_drop();
    test_reset_midshift();
`ifdef LED_DIM_EN
    test_dim();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
